controle_escrita_registradores: RTL and testbench

- Write-back arbiter and buffer in front of the register file's single write port (address, data, write enable).
- Accepts results from two producers, the ALU (ula) and data memory loads (mem), through valid/ready handshakes, and queues them in a small FIFO.
- Retires one write per cycle to the register file.
- Exports a per-register pending mask so decode can stall on registers with outstanding writes.

---
 rtl/controle_escrita_pkg.sv | 21 ++
 rtl/controle_escrita_registradores_fila_escrita.sv | 119 +++++++++++
 rtl/controle_escrita_registradores.sv | 111 +++++++++++
 tb/tb_controle_escrita_registradores.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_escrita_pkg.sv
// ----------------------------------------------------------------------------
// controle_escrita_pkg
//   Shared constants and types for the register-file write-back path.
//   - LARG_END               : register address width (5 bits, 32 registers)
//   - *_PADRAO               : default word width, register count and depth
//   - entrada_escrita_t      : one queued write {end_reg, dado} at the default
//                              word width
// ----------------------------------------------------------------------------
package controle_escrita_pkg;

    localparam int LARG_END               = 5;
    localparam int TAMANHO_PALAVRA_PADRAO = 32;
    localparam int TAM_MEMORIA_PADRAO     = 32;
    localparam int PROFUNDIDADE_PADRAO    = 4;

    typedef struct packed {
        logic [LARG_END-1:0]               end_reg;
        logic [TAMANHO_PALAVRA_PADRAO-1:0] dado;
    } entrada_escrita_t;

endpackage

// File: rtl/controle_escrita_registradores_fila_escrita.sv
// ----------------------------------------------------------------------------
// fila_escrita
//   Circular FIFO of pending register-file writes.
//   - Two ordered write ports: port a is enqueued before port b when both
//     are active in the same cycle.
//   - One read port: the head entry is shown combinationally and is removed
//     on every edge where le=1.
//   - Publishes occupancy, empty/full flags and a per-register pending mask.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     escreve_a/end_a/dado_a   first write port
//     escreve_b/end_b/dado_b   second write port
//     le                       pop the head this edge
//     end_cabeca/dado_cabeca   head entry, 0 when empty
//     contagem, vazia, cheia   occupancy state
//     pendente                 bit i = some occupied entry targets register i
// ----------------------------------------------------------------------------
module fila_escrita
    import controle_escrita_pkg::*;
#(
    parameter  int LARG_DADO = TAMANHO_PALAVRA_PADRAO,
    parameter  int NUM_REGS  = TAM_MEMORIA_PADRAO,
    parameter  int PROF      = PROFUNDIDADE_PADRAO,
    localparam int LARG_PTR  = $clog2(PROF),
    localparam int LARG_CONT = $clog2(PROF + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 escreve_a,
    input  logic [LARG_END-1:0]  end_a,
    input  logic [LARG_DADO-1:0] dado_a,
    input  logic                 escreve_b,
    input  logic [LARG_END-1:0]  end_b,
    input  logic [LARG_DADO-1:0] dado_b,
    input  logic                 le,
    output logic [LARG_END-1:0]  end_cabeca,
    output logic [LARG_DADO-1:0] dado_cabeca,
    output logic [LARG_CONT-1:0] contagem,
    output logic                 vazia,
    output logic                 cheia,
    output logic [NUM_REGS-1:0]  pendente
);

    typedef struct packed {
        logic [LARG_END-1:0]  end_reg;
        logic [LARG_DADO-1:0] dado;
    } entrada_t;

    entrada_t             fila_q [PROF];
    entrada_t             fila_d [PROF];
    logic [LARG_PTR-1:0]  rd_q, rd_d;
    logic [LARG_PTR-1:0]  wr_q, wr_d;
    logic [LARG_PTR-1:0]  wr_b;
    logic [LARG_CONT-1:0] cont_q, cont_d;
    logic [LARG_PTR-1:0]  deslocamento;

    // NOTE: always_comb uses blocking assignments and gives every output a
    // default first, so no path leaves a variable unassigned (no latches).
    always_comb begin
        fila_d = fila_q;
        // Port b lands right after port a when both write this cycle.
        wr_b   = escreve_a ? wr_q + LARG_PTR'(1) : wr_q;
        if (escreve_a) fila_d[wr_q] = '{end_reg: end_a, dado: dado_a};
        if (escreve_b) fila_d[wr_b] = '{end_reg: end_b, dado: dado_b};
        wr_d   = wr_q + LARG_PTR'(escreve_a) + LARG_PTR'(escreve_b);
        rd_d   = rd_q + LARG_PTR'(le);
        cont_d = cont_q + LARG_CONT'(escreve_a) + LARG_CONT'(escreve_b)
               - LARG_CONT'(le);
    end

    // NOTE: state flops use non-blocking assignments; reset wins over any
    // same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cont_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cont_q <= cont_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy alone
    // decides which slots are meaningful, so stale contents are never seen.
    always_ff @(posedge clk) begin
        fila_q <= fila_d;
    end

    assign contagem = cont_q;
    assign vazia    = (cont_q == '0);
    assign cheia    = (cont_q == LARG_CONT'(PROF));

    always_comb begin
        end_cabeca  = '0;
        dado_cabeca = '0;
        if (!vazia) begin
            end_cabeca  = fila_q[rd_q].end_reg;
            dado_cabeca = fila_q[rd_q].dado;
        end
    end

    // A slot is occupied when its distance from the read pointer (modulo
    // the depth) is below the occupancy count.
    always_comb begin
        pendente     = '0;
        deslocamento = '0;
        for (int i = 0; i < PROF; i++) begin
            deslocamento = LARG_PTR'(i) - rd_q;
            if (LARG_CONT'(deslocamento) < cont_q) begin
                for (int j = 0; j < NUM_REGS; j++) begin
                    if (fila_q[i].end_reg == LARG_END'(j)) pendente[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/controle_escrita_registradores.sv
// ----------------------------------------------------------------------------
// controle_escrita_registradores
//   Write-back arbiter in front of the single register-file write port.
//   Accepts ALU (ula) and load (mem) results through valid/ready handshakes,
//   queues them in fila_escrita and retires one write per cycle.
//   Build option: DESCARTA_REG_ZERO_EN -- when defined, transfers that target
//   register 0 complete their handshake but are dropped instead of queued.
//   Ports:
//     clk, rst                               clock, sync active-high reset
//     mem_valido/mem_pronto/mem_end/mem_dado load-result handshake
//     ula_valido/ula_pronto/ula_end/ula_dado ALU-result handshake
//     end_reg_3/dado_escrita/escrita         register-file write port
//     pendente                               registers with queued writes
//     contagem/fila_vazia/fila_cheia         queue occupancy
// ----------------------------------------------------------------------------
module controle_escrita_registradores
    import controle_escrita_pkg::*;
#(
    parameter int tamanho_palavra   = TAMANHO_PALAVRA_PADRAO,
    parameter int tam_memoria       = TAM_MEMORIA_PADRAO,
    parameter int profundidade_fila = PROFUNDIDADE_PADRAO
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     mem_valido,
    output logic                                     mem_pronto,
    input  logic [LARG_END-1:0]                      mem_end,
    input  logic [tamanho_palavra-1:0]               mem_dado,
    input  logic                                     ula_valido,
    output logic                                     ula_pronto,
    input  logic [LARG_END-1:0]                      ula_end,
    input  logic [tamanho_palavra-1:0]               ula_dado,
    output logic [LARG_END-1:0]                      end_reg_3,
    output logic [tamanho_palavra-1:0]               dado_escrita,
    output logic                                     escrita,
    output logic [tam_memoria-1:0]                   pendente,
    output logic [$clog2(profundidade_fila+1)-1:0]   contagem,
    output logic                                     fila_vazia,
    output logic                                     fila_cheia
);

    localparam int LARG_CONT = $clog2(profundidade_fila + 1);

    logic [LARG_CONT-1:0]   livre;
    logic                   mem_ocupa;
    logic                   mem_transf, ula_transf;
    logic                   mem_enfileira, ula_enfileira;
    logic [tam_memoria-1:0] pendente_fila;

    always_comb begin
        // Capacity comes from registered occupancy only; a pop this cycle
        // does not free a slot for a push this cycle.
        livre = LARG_CONT'(profundidade_fila) - contagem;

`ifdef DESCARTA_REG_ZERO_EN
        // A load aimed at register 0 is dropped, so it does not take the
        // slot the ALU result would otherwise need.
        mem_ocupa     = mem_valido && (mem_end != '0);
`else
        mem_ocupa     = mem_valido;
`endif

        mem_pronto = (livre != '0);
        ula_pronto = (livre >= LARG_CONT'(2)) || ((livre != '0) && !mem_ocupa);

        mem_transf = mem_valido && mem_pronto;
        ula_transf = ula_valido && ula_pronto;

`ifdef DESCARTA_REG_ZERO_EN
        mem_enfileira = mem_transf && (mem_end != '0);
        ula_enfileira = ula_transf && (ula_end != '0);
`else
        mem_enfileira = mem_transf;
        ula_enfileira = ula_transf;
`endif
    end

    // The register file is always ready, so the head retires whenever present.
    assign escrita = !fila_vazia;

    // mem occupies port a so it is enqueued ahead of a same-cycle ula result;
    // a write pair to the same register therefore leaves the ALU value last.
    fila_escrita #(
        .LARG_DADO (tamanho_palavra),
        .NUM_REGS  (tam_memoria),
        .PROF      (profundidade_fila)
    ) u_fila (
        .clk         (clk),
        .rst         (rst),
        .escreve_a   (mem_enfileira),
        .end_a       (mem_end),
        .dado_a      (mem_dado),
        .escreve_b   (ula_enfileira),
        .end_b       (ula_end),
        .dado_b      (ula_dado),
        .le          (escrita),
        .end_cabeca  (end_reg_3),
        .dado_cabeca (dado_escrita),
        .contagem    (contagem),
        .vazia       (fila_vazia),
        .cheia       (fila_cheia),
        .pendente    (pendente_fila)
    );

`ifdef DESCARTA_REG_ZERO_EN
    assign pendente = {pendente_fila[tam_memoria-1:1], 1'b0};
`else
    assign pendente = pendente_fila;
`endif

endmodule

// File: tb/tb_controle_escrita_registradores.sv
// ----------------------------------------------------------------------------
// tb_controle_escrita_registradores
//   Self-checking bench for controle_escrita_registradores with default
//   parameters. A queue of pending writes serves as the reference: readiness,
//   head, occupancy and the pending mask are all derived from that queue.
// ----------------------------------------------------------------------------
module tb_controle_escrita_registradores;
    import controle_escrita_pkg::*;

    localparam int PW   = 32;
    localparam int NR   = 32;
    localparam int PROF = 4;
    localparam int CW   = $clog2(PROF + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valido, ula_valido;
    logic          mem_pronto, ula_pronto;
    logic [4:0]    mem_end, ula_end;
    logic [PW-1:0] mem_dado, ula_dado;
    logic [4:0]    end_reg_3;
    logic [PW-1:0] dado_escrita;
    logic          escrita;
    logic [NR-1:0] pendente;
    logic [CW-1:0] contagem;
    logic          fila_vazia, fila_cheia;

    always #5 clk = ~clk;

    controle_escrita_registradores #(
        .tamanho_palavra   (PW),
        .tam_memoria       (NR),
        .profundidade_fila (PROF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valido   (mem_valido),
        .mem_pronto   (mem_pronto),
        .mem_end      (mem_end),
        .mem_dado     (mem_dado),
        .ula_valido   (ula_valido),
        .ula_pronto   (ula_pronto),
        .ula_end      (ula_end),
        .ula_dado     (ula_dado),
        .end_reg_3    (end_reg_3),
        .dado_escrita (dado_escrita),
        .escrita      (escrita),
        .pendente     (pendente),
        .contagem     (contagem),
        .fila_vazia   (fila_vazia),
        .fila_cheia   (fila_cheia)
    );

    int               checks = 0;
    int               errors = 0;
    entrada_escrita_t modelo[$];
    logic [4:0]       log_end[$];
    logic [PW-1:0]    log_dado[$];
    bit               mem_xfer, ula_xfer;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit descarta(input logic [4:0] a);
`ifdef DESCARTA_REG_ZERO_EN
        return (a == 5'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: called just after a falling edge with inputs already set.
    task automatic ciclo();
        int               livre;
        bit               exp_mr, exp_ur;
        logic [NR-1:0]    exp_pend;
        entrada_escrita_t cab;
        #1;
        livre    = PROF - modelo.size();
        exp_mr   = (livre >= 1);
        exp_ur   = (livre >= 2) || ((livre >= 1) && !(mem_valido && !descarta(mem_end)));
        exp_pend = '0;
        foreach (modelo[k]) exp_pend[modelo[k].end_reg] = 1'b1;
        cab = '0;
        if (modelo.size() > 0) cab = modelo[0];

        check("escrita",      escrita,      modelo.size() != 0);
        check("end_reg_3",    end_reg_3,    cab.end_reg);
        check("dado_escrita", dado_escrita, cab.dado);
        check("pendente",     pendente,     exp_pend);
        check("contagem",     contagem,     modelo.size());
        check("fila_vazia",   fila_vazia,   modelo.size() == 0);
        check("fila_cheia",   fila_cheia,   modelo.size() == PROF);
        check("mem_pronto",   mem_pronto,   exp_mr);
        check("ula_pronto",   ula_pronto,   exp_ur);

        if (escrita === 1'b1) begin
            log_end.push_back(end_reg_3);
            log_dado.push_back(dado_escrita);
        end
        mem_xfer = mem_valido && exp_mr;
        ula_xfer = ula_valido && exp_ur;

        @(posedge clk);
        if (rst) begin
            modelo.delete();
        end else begin
            if (modelo.size() > 0) void'(modelo.pop_front());
            if (mem_xfer && !descarta(mem_end))
                modelo.push_back('{end_reg: mem_end, dado: mem_dado});
            if (ula_xfer && !descarta(ula_end))
                modelo.push_back('{end_reg: ula_end, dado: ula_dado});
        end
        @(negedge clk);
    endtask

    task automatic ocioso();
        mem_valido = 1'b0;
        ula_valido = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ordem [8];
        int im, iu, guarda;
        ordem = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd4, 5'd13, 5'd14};

        // Reset, then idle
        rst = 1'b1;
        mem_valido = 1'b0; ula_valido = 1'b0;
        mem_end = '0; ula_end = '0; mem_dado = '0; ula_dado = '0;
        mem_xfer = 1'b0; ula_xfer = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ciclo();
        ciclo();

        // Single ALU push: reg 5 <- 0xDEADBEEF
        ula_valido = 1'b1; ula_end = 5'd5; ula_dado = 32'hDEADBEEF;
        ciclo();
        ocioso();
        #1;
        check("alu_escrita", escrita, 1);
        check("alu_end",     end_reg_3, 5);
        check("alu_dado",    dado_escrita, 32'hDEADBEEF);
        check("alu_pend5",   pendente[5], 1);
        ciclo();
        #1;
        check("alu_escrita_fim", escrita, 0);
        check("alu_pend5_fim",   pendente[5], 0);
        ciclo();

        // Both producers streaming, holding each item until accepted
        log_end.delete(); log_dado.delete();
        im = 0; iu = 0; guarda = 0;
        while ((im < 4 || iu < 4 || modelo.size() > 0) && guarda < 40) begin
            mem_valido = (im < 4); mem_end = 5'(1 + im);  mem_dado = 32'h100 + im;
            ula_valido = (iu < 4); ula_end = 5'(11 + iu); ula_dado = 32'h200 + iu;
            ciclo();
            if (mem_xfer) im++;
            if (ula_xfer) iu++;
            guarda++;
        end
        ocioso();
        check("rajada_prazo", guarda < 40, 1);
        check("rajada_qtd", log_end.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < log_end.size()) check("rajada_ordem", log_end[k], ordem[k]);
        end

        // Same register from both producers: load first, ALU last
        log_end.delete(); log_dado.delete();
        mem_valido = 1'b1; mem_end = 5'd7; mem_dado = 32'h1;
        ula_valido = 1'b1; ula_end = 5'd7; ula_dado = 32'h2;
        ciclo();
        ocioso();
        #1; check("mesmo_pend7_a", pendente[7], 1);
        ciclo();
        #1; check("mesmo_pend7_b", pendente[7], 1);
        ciclo();
        #1; check("mesmo_pend7_c", pendente[7], 0);
        ciclo();
        check("mesmo_qtd", log_dado.size(), 2);
        if (log_dado.size() == 2) begin
            check("mesmo_primeiro", log_dado[0], 32'h1);
            check("mesmo_segundo",  log_dado[1], 32'h2);
        end

        // Reset with three entries queued
        mem_valido = 1'b1; mem_end = 5'd20; mem_dado = 32'hA0;
        ula_valido = 1'b1; ula_end = 5'd21; ula_dado = 32'hA1;
        ciclo();
        mem_end = 5'd22; mem_dado = 32'hA2;
        ula_end = 5'd23; ula_dado = 32'hA3;
        ciclo();
        #1; check("rst_pre_contagem", contagem, 3);
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
        ocioso();
        #1;
        check("rst_contagem", contagem, 0);
        check("rst_escrita",  escrita, 0);
        check("rst_pendente", pendente, 0);
        log_end.delete(); log_dado.delete();
        ciclo();
        ciclo();
        ciclo();
        check("rst_sem_escritas", log_end.size(), 0);

        // Push targeting register 0
        log_end.delete(); log_dado.delete();
        ula_valido = 1'b1; ula_end = 5'd0; ula_dado = 32'h55;
        ciclo();
        check("zero_handshake", ula_xfer, 1);
        ocioso();
        #1;
`ifdef DESCARTA_REG_ZERO_EN
        check("zero_escrita",  escrita, 0);
        check("zero_contagem", contagem, 0);
`else
        check("zero_escrita", escrita, 1);
        check("zero_end",     end_reg_3, 0);
        check("zero_dado",    dado_escrita, 32'h55);
`endif
        ciclo();
        ciclo();
`ifdef DESCARTA_REG_ZERO_EN
        check("zero_qtd", log_end.size(), 0);
`else
        check("zero_qtd", log_end.size(), 1);
`endif

        // Random traffic; producers hold an offer until it is accepted
        mem_xfer = 1'b0; ula_xfer = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!mem_valido || mem_xfer) begin
                mem_valido = 1'($urandom_range(0, 1));
                mem_end    = 5'($urandom_range(0, 31));
                mem_dado   = $urandom;
            end
            if (!ula_valido || ula_xfer) begin
                ula_valido = 1'($urandom_range(0, 1));
                ula_end    = 5'($urandom_range(0, 31));
                ula_dado   = $urandom;
            end
            rst = ($urandom_range(0, 63) == 0);
            ciclo();
        end
        rst = 1'b0;
        ocioso();
        for (int n = 0; n < 6; n++) ciclo();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
